// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants and the fetch queue entry type
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry FIFO of {instr, pc} with flush and occupancy count
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // pointers wrap naturally because DEPTH is a power of two
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - in-order instruction prefetch with credit-limited issue and redirect flush
module inst_fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_EXT = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic          accept, rsp_ok, drop, push, pop;
  logic [CW-1:0] count;
  fetch_entry_t  head, push_data;

  always_comb begin
    // credit counts in-flight requests too, so a push can never find the queue full
    imem_req_valid = rst_n && !redirect_valid &&
                     (({1'b0, count} + {1'b0, outstanding_q}) < DEPTH_EXT);
    accept = imem_req_valid && imem_req_ready;
    rsp_ok = imem_rsp_valid && (outstanding_q != '0);
    drop   = rsp_ok && (drop_cnt_q != '0);
    push   = rsp_ok && !drop && !redirect_valid;
    pop    = id_valid && id_ready && !redirect_valid;

    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_ok);

    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      rsp_pc_d   = word_align(redirect_pc);
      drop_cnt_d = outstanding_d;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (drop)   drop_cnt_d = drop_cnt_q - CW'(1);
      if (push)   rsp_pc_d   = rsp_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign push_data.instr = imem_rsp_data;
  assign push_data.pc    = rsp_pc_q;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

  assign imem_req_addr = fetch_pc_q;
  assign id_valid      = (count != '0);
  assign id_instr      = id_valid ? head.instr : NOP_INSTR;
  assign id_pc         = id_valid ? head.pc : '0;

  assert property (@(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb/tb_inst_fetch_buffer.sv - self-checking bench for inst_fetch_buffer
module tb_inst_fetch_buffer;
  import riscv_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;

  always #5 clk = ~clk;

  inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // memory model: accepted requests tagged with the redirect epoch they belong to
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] held_q[$];
  logic [31:0] pops[$];
  logic [31:0] m_pc;
  int          epoch = 0;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  logic        s_req_valid, s_id_valid;
  logic [31:0] s_req_addr, s_id_pc, s_id_instr;

  task automatic tick(input logic redir, input logic [31:0] rpc, input logic idr, input logic rdy);
    bit          acc, pop, rsp;
    pend_t       r;
    logic [31:0] p;
    logic        exp_rv;
    redirect_valid = redir;
    redirect_pc    = rpc;
    id_ready       = idr;
    imem_req_ready = rdy;
    rsp = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(pend_q[0].addr) : 32'h0;
    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_id_valid  = id_valid;
    s_id_pc     = id_pc;
    s_id_instr  = id_instr;
    chk("id_valid", s_id_valid, held_q.size() > 0);
    if (held_q.size() > 0) begin
      chk("id_pc", s_id_pc, held_q[0]);
      chk("id_instr", s_id_instr, mem_word(held_q[0]));
    end else begin
      chk("idle_instr", s_id_instr, NOP_INSTR);
      chk("idle_pc", s_id_pc, 32'h0);
    end
    exp_rv = !redir && ((held_q.size() + pend_q.size()) < DEPTH);
    chk("req_valid", s_req_valid, exp_rv);
    if (s_req_valid && exp_rv) chk("req_addr", s_req_addr, m_pc);
    acc = s_req_valid && rdy;
    pop = s_id_valid && idr;
    @(posedge clk);
    if (rsp) r = pend_q.pop_front();
    if (redir) begin
      held_q.delete();
      epoch++;
      m_pc = rpc & ~32'h3;
    end else begin
      if (pop && held_q.size() > 0) begin
        p = held_q.pop_front();
        pops.push_back(p);
      end
      if (rsp && r.epoch == epoch) held_q.push_back(r.addr);
      if (acc) begin
        pend_q.push_back('{addr: s_req_addr, epoch: epoch,
                           due: cyc + int'($urandom_range(lat_max, lat_min))});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    id_ready       = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_id_valid", id_valid, 1'b0);
    chk("rst_id_instr", id_instr, NOP_INSTR);
    chk("rst_id_pc", id_pc, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pend_q.delete();
    held_q.delete();
    pops.delete();
    m_pc = RPC;
    cyc  = 0;
  endtask

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int first, thru, base;

    vecs[0] = '{32'h0000_0100, 32'h0000_0100};
    vecs[1] = '{32'h0000_0203, 32'h0000_0200};
    vecs[2] = '{32'h8000_0007, 32'h8000_0004};
    vecs[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC};

    #2;
    // streaming with 1-cycle memory
    do_reset();
    lat_min = 1; lat_max = 1;
    first = -1; thru = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 32'h0, 1'b1, 1'b1);
      if (i == 0) chk("first_req_addr", s_req_addr, RPC);
      if (s_id_valid && first < 0) first = i;
      if (i >= 2 && s_id_valid) thru++;
    end
    chk("first_id_cycle", first, 2);
    chk("throughput", thru, 18);
    chk("pop0_pc", pops[0], 32'h0);
    chk("pop5_pc", pops[5], 32'h14);

    // decode stall fills exactly DEPTH entries
    do_reset();
    for (int i = 0; i < 10; i++) tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("stall_req_valid", s_req_valid, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) chk("stall_release_pc", pops[i], 32'(i * 4));

    // redirect with two outstanding on 3-cycle memory
    do_reset();
    lat_min = 3; lat_max = 3;
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b1, 32'h0000_0100, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    chk("redir3_next_addr", s_req_addr, 32'h0000_0100);
    for (int i = 0; i < 30 && pops.size() == 0; i++) tick(1'b0, 32'h0, 1'b1, 1'b1);
    chk("redir3_delivered", pops.size() > 0, 1'b1);
    if (pops.size() > 0) chk("redir3_first_pc", pops[0], 32'h0000_0100);

    // redirect coincident with response and pop
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) tick(1'b0, 32'h0, 1'b1, 1'b1);
    base = pops.size();
    tick(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    chk("coinc_pre_id_valid", s_id_valid, 1'b1);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    chk("coinc_req_valid", s_req_valid, 1'b1);
    chk("coinc_req_addr", s_req_addr, 32'h0000_0100);
    chk("coinc_id_valid", s_id_valid, 1'b0);
    for (int i = 0; i < 20 && pops.size() <= base; i++) tick(1'b0, 32'h0, 1'b1, 1'b1);
    chk("coinc_delivered", pops.size() > base, 1'b1);
    if (pops.size() > base) chk("coinc_first_pc", pops[base], 32'h0000_0100);

    // redirect alignment table, then address wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, vecs[i].rpc, 1'b0, 1'b0);
      chk("vec_rv_during", s_req_valid, 1'b0);
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      chk("vec_rv_after", s_req_valid, 1'b1);
      chk("vec_addr", s_req_addr, vecs[i].exp_addr);
    end
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_addr", s_req_addr, 32'h0);
    for (int i = 0; i < 20 && pops.size() < 2; i++) tick(1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_delivered", pops.size() >= 2, 1'b1);
    if (pops.size() >= 2) begin
      chk("wrap_pc0", pops[0], 32'hFFFF_FFFC);
      chk("wrap_pc1", pops[1], 32'h0);
    end

    // randomized traffic
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(99) < 5, $urandom, $urandom_range(9) < 7, $urandom_range(9) < 7);
    end

    // reset mid-stream with a full queue
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) tick(1'b0, 32'h0, 1'b0, 1'b1);
    chk("full_pre_id_valid", s_id_valid, 1'b1);
    do_reset();
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    chk("post_rst_req_valid", s_req_valid, 1'b1);
    chk("post_rst_req_addr", s_req_addr, RPC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
